// File: rtl/led_mode_ctrl_if.sv
// Front-panel pin bundle for led_mode_ctrl: raw push-switches in, LEDs out.
interface led_mode_ctrl_if;
  logic i_Switch_1;
  logic i_Switch_2;
  logic i_Switch_3;
  logic o_LED_1;
  logic o_LED_2;
  logic o_LED_3;
  logic o_LED_4;

  modport master (
    output i_Switch_1, i_Switch_2, i_Switch_3,
    input  o_LED_1, o_LED_2, o_LED_3, o_LED_4
  );

  modport slave (
    input  i_Switch_1, i_Switch_2, i_Switch_3,
    output o_LED_1, o_LED_2, o_LED_3, o_LED_4
  );
endinterface

// File: rtl/led_mode_ctrl.sv
// Go Board front-panel controller: switch sync/debounce, 4-mode FSM stepped by
// switch 3 release, LED 1 logic function or blink, mode and switch 3 on LEDs 2-4.
module led_mode_ctrl #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned BLINK_LIMIT    = 12500000
) (
  input logic            i_Clk,
  input logic            i_Rst_L,
  led_mode_ctrl_if.slave pins
);

  localparam int unsigned NSW    = 3;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_LIMIT);
  localparam int unsigned BCNT_W = $clog2(BLINK_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_ARM   = CNT_W'(DEBOUNCE_LIMIT - 2);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_LIMIT - 1);

  typedef enum logic [1:0] {
    MODE_AND   = 2'b00,
    MODE_OR    = 2'b01,
    MODE_XOR   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_t;

  logic [NSW-1:0]    raw;
  logic [NSW-1:0]    sync1;
  logic [NSW-1:0]    sync2;
  logic [NSW-1:0]    deb;
  logic              deb3_prev;
  mode_t             mode;
  logic [BCNT_W-1:0] bcnt;
  logic              blink;

  assign raw = {pins.i_Switch_3, pins.i_Switch_2, pins.i_Switch_1};

  // Two-flop synchronizer for all three pins
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-switch debounce: sync2 supplies the first L-1 differing samples and
  // sync1 the L-th, so the accepted level lands L edges after sync1 changes.
  for (genvar g = 0; g < NSW; g++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             deb_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        cnt   <= '0;
        deb_q <= 1'b0;
      end else if (sync2[g] != deb_q) begin
        if (cnt == CNT_ARM && sync1[g] != deb_q) begin
          deb_q <= sync1[g];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end

    assign deb[g] = deb_q;
  end

  // Mode FSM: one step per debounced release of switch 3
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      deb3_prev <= 1'b0;
      mode      <= MODE_AND;
    end else begin
      deb3_prev <= deb[2];
      if (deb3_prev && !deb[2]) begin
        case (mode)
          MODE_AND: mode <= MODE_OR;
          MODE_OR:  mode <= MODE_XOR;
          MODE_XOR: mode <= MODE_BLINK;
          default:  mode <= MODE_AND;
        endcase
      end
    end
  end

  // Blink generator, parked at zero outside BLINK so each entry starts dark
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (mode != MODE_BLINK) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (bcnt == BCNT_LAST) begin
      bcnt  <= '0;
      blink <= ~blink;
    end else begin
      bcnt <= bcnt + BCNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pins.o_LED_1 <= 1'b0;
      pins.o_LED_2 <= 1'b0;
      pins.o_LED_3 <= 1'b0;
      pins.o_LED_4 <= 1'b0;
    end else begin
      case (mode)
        MODE_AND: pins.o_LED_1 <= deb[0] & deb[1];
        MODE_OR:  pins.o_LED_1 <= deb[0] | deb[1];
        MODE_XOR: pins.o_LED_1 <= deb[0] ^ deb[1];
        default:  pins.o_LED_1 <= blink;
      endcase
      pins.o_LED_2 <= mode[1];
      pins.o_LED_3 <= mode[0];
      pins.o_LED_4 <= deb[2];
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scenario bench for led_mode_ctrl with DEBOUNCE_LIMIT=4, BLINK_LIMIT=3.
// Expected LED vectors {LED1,LED2,LED3,LED4} are queued per edge and popped as edges occur.
module tb_led_mode_ctrl;

  localparam int unsigned DEB_L = 4;
  localparam int unsigned BLK_L = 3;

  typedef struct {
    int unsigned at;
    logic [3:0]  leds;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  leds;
  exp_t        sb[$];
  int unsigned edge_no = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  led_mode_ctrl_if pins ();

  led_mode_ctrl #(
    .DEBOUNCE_LIMIT(DEB_L),
    .BLINK_LIMIT   (BLK_L)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .pins   (pins)
  );

  always #5 clk = ~clk;

  assign leds = {pins.o_LED_1, pins.o_LED_2, pins.o_LED_3, pins.o_LED_4};

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic push_exp(input logic [3:0] v);
    exp_t e;
    e.at   = edge_no + 1;
    e.leds = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic s1, input logic s2, input logic s3);
    pins.i_Switch_1 = s1;
    pins.i_Switch_2 = s2;
    pins.i_Switch_3 = s3;
  endtask

  // All switches high through reset; everything dark until edge 6 after release.
  task automatic test_reset();
    exp_t got;
    drive(1'b1, 1'b1, 1'b1);
    for (int t = 1; t <= 11; t++) begin
      rst_n = (t > 3);
      push_exp((t >= 9) ? 4'b1001 : 4'b0000);
      tick();
      while (sb.size() != 0 && sb[0].at <= edge_no) begin
        got = sb.pop_front();
        n_tests++;
        if (leds !== got.leds) begin
          n_fail++;
          $display("FAIL reset t=%0d: leds=%b expected %b", t, leds, got.leds);
        end
      end
    end
  endtask

  // Switch 2 high; a 3-cycle switch 1 glitch is dropped, a 4-cycle pulse passes.
  task automatic test_glitch();
    exp_t got;
    logic s1;
    logic [3:0] v;
    for (int t = 1; t <= 36; t++) begin
      rst_n = (t > 2);
      v = 4'b0000;
      if (t <= 10) begin
        s1 = 1'b0;
      end else if (t <= 22) begin
        s1 = (t - 10 <= 3);
      end else begin
        s1 = (t - 22 <= 4);
        if (t - 22 >= 6 && t - 22 <= 9) v = 4'b1000;
      end
      drive(s1, 1'b1, 1'b0);
      push_exp(v);
      tick();
      while (sb.size() != 0 && sb[0].at <= edge_no) begin
        got = sb.pop_front();
        n_tests++;
        if (leds !== got.leds) begin
          n_fail++;
          $display("FAIL glitch t=%0d: leds=%b expected %b", t, leds, got.leds);
        end
      end
    end
  endtask

  // Four press/release cycles of switch 3 (10 cycles per level); mode shows at release+7.
  task automatic test_mode_cycle();
    exp_t got;
    int ph;
    int steps;
    logic [1:0] md;
    logic l1;
    logic l4;
    for (int t = 1; t <= 80; t++) begin
      ph    = (t - 1) % 20;
      l4    = (ph >= 5 && ph < 15);
      steps = (t >= 17) ? ((t - 17) / 20 + 1) : 0;
      md    = 2'(steps % 4);
      case (md)
        2'd0:    l1 = 1'b0;
        2'd1:    l1 = 1'b1;
        2'd2:    l1 = 1'b1;
        default: l1 = (((t - 57) / 3) % 2) != 0;
      endcase
      drive(1'b0, 1'b1, ph < 10);
      push_exp({l1, md, l4});
      tick();
      while (sb.size() != 0 && sb[0].at <= edge_no) begin
        got = sb.pop_front();
        n_tests++;
        if (leds !== got.leds) begin
          n_fail++;
          $display("FAIL mode_cycle t=%0d: leds=%b expected %b", t, leds, got.leds);
        end
      end
    end
  endtask

  // Truth table of LED 1 in AND, OR, XOR over {sw1,sw2} = 00,01,10,11.
  task automatic test_function_table();
    exp_t got;
    logic [3:0] fn [3];
    logic [1:0] pat;
    logic [1:0] mi;
    int n;
    fn[0] = 4'b1000;
    fn[1] = 4'b1110;
    fn[2] = 4'b0110;
    for (int m = 0; m < 3; m++) begin
      n = (m < 2) ? 52 : 32;
      for (int k = 1; k <= n; k++) begin
        if (k <= 32) begin
          pat = 2'((k - 1) / 8);
          drive(pat[1], pat[0], 1'b0);
          mi = 2'(m);
          if (k % 8 == 0) push_exp({fn[mi][pat], mi, 1'b0});
        end else begin
          drive(1'b1, 1'b1, (k - 32) <= 10);
          mi = 2'(m + 1);
          if (k == 52) push_exp({fn[mi][3], mi, 1'b0});
        end
        tick();
        while (sb.size() != 0 && sb[0].at <= edge_no) begin
          got = sb.pop_front();
          n_tests++;
          if (leds !== got.leds) begin
            n_fail++;
            $display("FAIL fn_table mode=%0d k=%0d: leds=%b expected %b", m, k, leds, got.leds);
          end
        end
      end
    end
  endtask

  // Enter BLINK from XOR with both switches high, then leave it back to AND.
  task automatic test_blink();
    exp_t got;
    logic [1:0] md;
    logic l1;
    logic l4;
    for (int t = 1; t <= 60; t++) begin
      l4 = (t >= 6 && t < 16) || (t >= 46 && t < 56);
      if (t <= 16) begin
        md = 2'b10;
        l1 = 1'b0;
      end else if (t <= 56) begin
        md = 2'b11;
        l1 = (((t - 17) / 3) % 2) != 0;
      end else begin
        md = 2'b00;
        l1 = 1'b1;
      end
      drive(1'b1, 1'b1, (t <= 10) || (t >= 41 && t <= 50));
      push_exp({l1, md, l4});
      tick();
      while (sb.size() != 0 && sb[0].at <= edge_no) begin
        got = sb.pop_front();
        n_tests++;
        if (leds !== got.leds) begin
          n_fail++;
          $display("FAIL blink t=%0d: leds=%b expected %b", t, leds, got.leds);
        end
      end
    end
  endtask

  // Async reset while LED 1 is lit in BLINK and switch 1 is partway through debounce.
  task automatic test_reset_async();
    exp_t got;
    logic [3:0] step_exp [3];
    step_exp[0] = 4'b1010;
    step_exp[1] = 4'b0100;
    step_exp[2] = 4'b1110;
    for (int j = 0; j < 3; j++) begin
      for (int k = 1; k <= 20; k++) begin
        drive(!(j == 2 && k >= 18), 1'b1, k <= 10);
        if (k == 20) push_exp(step_exp[j]);
        tick();
        while (sb.size() != 0 && sb[0].at <= edge_no) begin
          got = sb.pop_front();
          n_tests++;
          if (leds !== got.leds) begin
            n_fail++;
            $display("FAIL reset_async_setup step=%0d: leds=%b expected %b", j, leds, got.leds);
          end
        end
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (leds !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async_immediate: leds=%b expected 0000", leds);
    end
    drive(1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= 10; t++) begin
      rst_n = (t > 2);
      push_exp((t >= 8) ? 4'b1000 : 4'b0000);
      tick();
      while (sb.size() != 0 && sb[0].at <= edge_no) begin
        got = sb.pop_front();
        n_tests++;
        if (leds !== got.leds) begin
          n_fail++;
          $display("FAIL reset_async_recover t=%0d: leds=%b expected %b", t, leds, got.leds);
        end
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    #2;
    test_reset();
    test_glitch();
    test_mode_cycle();
    test_function_table();
    test_blink();
    test_reset_async();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
